// File: rtl/id_pkg.sv
// id_pkg: MIPS opcode/funct constants, control bundle and decode helper for the ID stage
package id_pkg;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  typedef enum logic [1:0] {EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2} ext_e;
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    ext_e ext_mode;
    logic is_branch;
    logic is_jump;
    logic uses_rs;
    logic uses_rt;
  } ctrl_t;
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R: begin
        if (funct == F_ADDU || funct == F_SUBU) begin
          c.regwrite = 1'b1;
          c.uses_rs = 1'b1;
          c.uses_rt = 1'b1;
        end else if (funct == F_JR) begin
          c.is_jump = 1'b1;
          c.uses_rs = 1'b1;
        end
      end
      OP_ORI: begin
        c.regwrite = 1'b1;
        c.uses_rs = 1'b1;
      end
      OP_LUI: begin
        c.regwrite = 1'b1;
        c.ext_mode = EXT_LUI;
      end
      OP_LW: begin
        c.regwrite = 1'b1;
        c.memread = 1'b1;
        c.ext_mode = EXT_SIGN;
        c.uses_rs = 1'b1;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.ext_mode = EXT_SIGN;
        c.uses_rs = 1'b1;
        c.uses_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.is_branch = 1'b1;
        c.ext_mode = EXT_SIGN;
        c.uses_rs = 1'b1;
        c.uses_rt = 1'b1;
      end
      OP_J: c.is_jump = 1'b1;
      OP_JAL: begin
        c.regwrite = 1'b1;
        c.is_jump = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/id_stage_grf_bypass.sv
// grf_bypass: 2R1W register file, register 0 hardwired to zero, same-cycle write visible on reads
module grf_bypass
  import id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_NUM = 32,
  localparam int ADDR_W = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] regs [REG_NUM];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    else if (we && wa != '0) regs[wa] <= wd;
  assign rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs[ra2];
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode with bypassed register read, branch/jump resolution, hazard stall and ID/EX register
module id_stage
  import id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_NUM = 32,
  parameter int LINK_REG = REG_NUM - 1,
  localparam int ADDR_W = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_instr,
  output logic              id_ready,
  output logic              br_taken,
  output logic [31:0]       br_target,
  input  logic              flush,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_instr,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_dst,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite
);
  logic [5:0] op;
  logic [15:0] imm;
  logic [ADDR_W-1:0] rs, rt, rd, dst;
  logic [DATA_W-1:0] rf1, rf2, op1, op2, ext;
  logic [31:0] pc4, sext32;
  logic is_jr, hazard, advance, ld;
  ctrl_t c;
  assign op = if_instr[31:26];
  assign imm = if_instr[15:0];
  assign rs = if_instr[21 +: ADDR_W];
  assign rt = if_instr[16 +: ADDR_W];
  assign rd = if_instr[11 +: ADDR_W];
  assign c = decode(op, if_instr[5:0]);
  grf_bypass #(.DATA_W(DATA_W), .REG_NUM(REG_NUM)) u_grf (
    .clk(clk), .reset(reset), .we(wb_we), .wa(wb_addr), .wd(wb_data),
    .ra1(rs), .ra2(rt), .rd1(rf1), .rd2(rf2)
  );
  // MEM beats WB; the register file already covers WB write-through and $0
  assign op1 = (rs != '0 && mem_we && mem_addr == rs) ? mem_data : rf1;
  assign op2 = (rt != '0 && mem_we && mem_addr == rt) ? mem_data : rf2;
  assign sext32 = 32'($signed(imm));
  assign ext = c.ext_mode == EXT_LUI ? DATA_W'({imm, 16'h0000}) :
               c.ext_mode == EXT_SIGN ? DATA_W'($signed(imm)) : DATA_W'(imm);
  assign is_jr = c.is_jump & (op == OP_R);
  assign dst = ~c.regwrite ? '0 : op == OP_R ? rd : op == OP_JAL ? ADDR_W'(LINK_REG) : rt;
  assign hazard = ex_valid & ex_regwrite & (ex_dst != '0) &
                  ((c.uses_rs & (rs == ex_dst)) | (c.uses_rt & (rt == ex_dst))) &
                  (ex_memread | c.is_branch | is_jr);
  assign advance = ~ex_valid | ex_ready;
  assign id_ready = flush | (advance & ~hazard);
  assign br_taken = if_valid & id_ready & ~flush &
                    ((c.is_branch & ((op1 == op2) ^ (op == OP_BNE))) | c.is_jump);
  assign pc4 = if_pc + 32'd4;
  assign br_target = ~br_taken ? pc4 :
                     c.is_branch ? pc4 + {sext32[29:0], 2'b00} :
                     is_jr ? op1[31:0] : {pc4[31:28], if_instr[25:0], 2'b00};
  assign ld = if_valid & ~hazard & ~flush;
  // bubbles and flushes clear the whole ID/EX word, not just the valid bit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_instr <= '0;
      ex_rd1 <= '0;
      ex_rd2 <= '0;
      ex_imm <= '0;
      ex_dst <= '0;
      ex_regwrite <= 1'b0;
      ex_memread <= 1'b0;
      ex_memwrite <= 1'b0;
    end else if (flush | advance) begin
      ex_valid <= ld;
      ex_pc <= ld ? if_pc : '0;
      ex_instr <= ld ? if_instr : '0;
      ex_rd1 <= ld ? op1 : '0;
      ex_rd2 <= ld ? op2 : '0;
      ex_imm <= ld ? ext : '0;
      ex_dst <= ld ? dst : '0;
      ex_regwrite <= ld & (dst != '0);
      ex_memread <= ld & c.memread;
      ex_memwrite <= ld & c.memwrite;
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage
module tb_id_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic if_valid = 1'b0, flush = 1'b0, mem_we = 1'b0, wb_we = 1'b0, ex_ready = 1'b1;
  logic [31:0] if_pc = '0, if_instr = '0, br_target, ex_pc, ex_instr;
  logic [4:0] mem_addr = '0, wb_addr = '0, ex_dst;
  logic [31:0] mem_data = '0, wb_data = '0, ex_rd1, ex_rd2, ex_imm;
  logic id_ready, br_taken, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  int total = 0, bad = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready), .br_taken(br_taken), .br_target(br_target), .flush(flush),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_dst(ex_dst),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'h00, f};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ex_valid); end
    total++; if (ex_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", ex_pc); end
    total++; if (ex_rd1 !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%h want=0", ex_rd1); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", id_ready); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_addu;
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    if_valid = 1'b1; if_pc = 32'h100; if_instr = r_ins(5'd1, 5'd2, 5'd3, 6'h21);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL addu_ready got=%0b want=1", id_ready); end
    total++; if (br_taken !== 1'b0 || br_target !== 32'h104) begin bad++; $display("FAIL addu_npc got=%0b/%h want=0/104", br_taken, br_target); end
    tick();
    if_valid = 1'b0;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL addu_valid got=%0b want=1", ex_valid); end
    total++; if (ex_rd1 !== 32'd5 || ex_rd2 !== 32'd7) begin bad++; $display("FAIL addu_ops got=%0d/%0d want=5/7", ex_rd1, ex_rd2); end
    total++; if (ex_dst !== 5'd3 || ex_regwrite !== 1'b1) begin bad++; $display("FAIL addu_dst got=%0d/%0b want=3/1", ex_dst, ex_regwrite); end
    total++; if (ex_pc !== 32'h100) begin bad++; $display("FAIL addu_pc got=%h want=100", ex_pc); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL idle_bubble got=%0b want=0", ex_valid); end
  endtask

  task automatic test_load_use;
    if_valid = 1'b1; if_pc = 32'h200; if_instr = i_ins(6'h23, 5'd0, 5'd4, 16'h0000);
    tick();
    if_pc = 32'h204; if_instr = r_ins(5'd4, 5'd4, 5'd5, 6'h21);
    #1;
    total++; if (ex_memread !== 1'b1 || ex_dst !== 5'd4) begin bad++; $display("FAIL lw_ctrl got=%0b/%0d want=1/4", ex_memread, ex_dst); end
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got=%0b want=0", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0b want=0", ex_valid); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL lu_resume got=%0b want=1", id_ready); end
    tick();
    if_valid = 1'b0;
    total++; if (ex_valid !== 1'b1 || ex_dst !== 5'd5 || ex_pc !== 32'h204) begin bad++; $display("FAIL lu_accept got=%0b/%0d/%h want=1/5/204", ex_valid, ex_dst, ex_pc); end
    tick();
  endtask

  task automatic test_branch;
    if_valid = 1'b1; if_pc = 32'h3000;
    if_instr = i_ins(6'h04, 5'd1, 5'd1, 16'd3);
    #1;
    total++; if (br_taken !== 1'b1 || br_target !== 32'h3010) begin bad++; $display("FAIL beq_taken got=%0b/%h want=1/3010", br_taken, br_target); end
    if_instr = i_ins(6'h04, 5'd1, 5'd2, 16'd3);
    #1;
    total++; if (br_taken !== 1'b0 || br_target !== 32'h3004) begin bad++; $display("FAIL beq_not got=%0b/%h want=0/3004", br_taken, br_target); end
    if_instr = i_ins(6'h05, 5'd1, 5'd2, 16'hFFFF);
    #1;
    total++; if (br_taken !== 1'b1 || br_target !== 32'h3000) begin bad++; $display("FAIL bne_back got=%0b/%h want=1/3000", br_taken, br_target); end
    if_instr = j_ins(6'h02, 26'h40);
    #1;
    total++; if (br_taken !== 1'b1 || br_target !== 32'h100) begin bad++; $display("FAIL j got=%0b/%h want=1/100", br_taken, br_target); end
    if_instr = r_ins(5'd2, 5'd0, 5'd0, 6'h08);
    #1;
    total++; if (br_taken !== 1'b1 || br_target !== 32'h7) begin bad++; $display("FAIL jr got=%0b/%h want=1/7", br_taken, br_target); end
    if_instr = j_ins(6'h03, 26'h80);
    #1;
    total++; if (br_taken !== 1'b1 || br_target !== 32'h200) begin bad++; $display("FAIL jal got=%0b/%h want=1/200", br_taken, br_target); end
    tick();
    total++; if (ex_dst !== 5'd31 || ex_regwrite !== 1'b1) begin bad++; $display("FAIL jal_dst got=%0d/%0b want=31/1", ex_dst, ex_regwrite); end
    if_instr = r_ins(5'd1, 5'd2, 5'd8, 6'h21);
    tick();
    if_instr = i_ins(6'h04, 5'd8, 5'd0, 16'd1);
    #1;
    total++; if (id_ready !== 1'b0 || br_taken !== 1'b0) begin bad++; $display("FAIL bu_stall got=%0b/%0b want=0/0", id_ready, br_taken); end
    tick();
    total++; if (ex_valid !== 1'b0 || br_taken !== 1'b1 || br_target !== 32'h3008) begin bad++; $display("FAIL bu_resume got=%0b/%0b/%h want=0/1/3008", ex_valid, br_taken, br_target); end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_forward;
    mem_we = 1'b1; mem_addr = 5'd6; mem_data = 32'hAA;
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'hBB;
    if_valid = 1'b1; if_pc = 32'h500; if_instr = i_ins(6'h0d, 5'd6, 5'd9, 16'h8001);
    tick();
    mem_we = 1'b0; wb_we = 1'b0;
    total++; if (ex_rd1 !== 32'hAA) begin bad++; $display("FAIL fwd_mem got=%h want=aa", ex_rd1); end
    total++; if (ex_imm !== 32'h00008001 || ex_dst !== 5'd9) begin bad++; $display("FAIL ori_imm got=%h/%0d want=00008001/9", ex_imm, ex_dst); end
    tick();
    total++; if (ex_rd1 !== 32'hBB) begin bad++; $display("FAIL rf_written got=%h want=bb", ex_rd1); end
    if_instr = i_ins(6'h0f, 5'd0, 5'd11, 16'h1234);
    tick();
    total++; if (ex_imm !== 32'h12340000 || ex_dst !== 5'd11) begin bad++; $display("FAIL lui got=%h/%0d want=12340000/11", ex_imm, ex_dst); end
    if_instr = i_ins(6'h23, 5'd1, 5'd4, 16'hFFFC);
    tick();
    total++; if (ex_imm !== 32'hFFFFFFFC || ex_rd1 !== 32'd5 || ex_memread !== 1'b1) begin bad++; $display("FAIL lw_sext got=%h/%h/%0b want=fffffffc/5/1", ex_imm, ex_rd1, ex_memread); end
    if_instr = i_ins(6'h2b, 5'd1, 5'd2, 16'h0008);
    tick();
    total++; if (ex_memwrite !== 1'b1 || ex_regwrite !== 1'b0 || ex_dst !== 5'd0 || ex_rd2 !== 32'd7) begin bad++; $display("FAIL sw_ctrl got=%0b/%0b/%0d/%h want=1/0/0/7", ex_memwrite, ex_regwrite, ex_dst, ex_rd2); end
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    if_instr = r_ins(5'd7, 5'd0, 5'd10, 6'h21);
    tick();
    wb_we = 1'b0; if_valid = 1'b0;
    total++; if (ex_rd1 !== 32'h77) begin bad++; $display("FAIL wb_through got=%h want=77", ex_rd1); end
    tick();
  endtask

  task automatic test_r0;
    wb_write(5'd0, 32'h1234);
    mem_we = 1'b1; mem_addr = 5'd0; mem_data = 32'h55;
    if_valid = 1'b1; if_pc = 32'h600; if_instr = r_ins(5'd0, 5'd0, 5'd12, 6'h21);
    tick();
    mem_we = 1'b0; if_valid = 1'b0;
    total++; if (ex_rd1 !== 32'h0 || ex_rd2 !== 32'h0) begin bad++; $display("FAIL r0_read got=%h/%h want=0/0", ex_rd1, ex_rd2); end
    if_valid = 1'b1; if_instr = 32'hFC00_0000;
    tick();
    if_valid = 1'b0;
    total++; if (ex_valid !== 1'b1 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 || ex_memwrite !== 1'b0) begin bad++; $display("FAIL unknown_op got=%0b/%0b/%0b/%0b want=1/0/0/0", ex_valid, ex_regwrite, ex_memread, ex_memwrite); end
    tick();
  endtask

  task automatic test_stall_flush;
    if_valid = 1'b1; if_pc = 32'h700; if_instr = r_ins(5'd1, 5'd2, 5'd3, 6'h21);
    tick();
    ex_ready = 1'b0; if_pc = 32'h704; if_instr = r_ins(5'd2, 5'd1, 5'd4, 6'h23);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL stall_ready%0d got=%0b want=0", i, id_ready); end
      tick();
      total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h700 || ex_rd1 !== 32'd5) begin bad++; $display("FAIL stall_hold%0d got=%0b/%h/%h want=1/700/5", i, ex_valid, ex_pc, ex_rd1); end
    end
    flush = 1'b1; if_instr = j_ins(6'h02, 26'h40);
    #1;
    total++; if (br_taken !== 1'b0 || id_ready !== 1'b1) begin bad++; $display("FAIL flush_comb got=%0b/%0b want=0/1", br_taken, id_ready); end
    tick();
    flush = 1'b0; if_valid = 1'b0;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_kill got=%0b want=0", ex_valid); end
    ex_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_stall;
    if_valid = 1'b1; if_pc = 32'h800; if_instr = r_ins(5'd1, 5'd2, 5'd3, 6'h21);
    tick();
    ex_ready = 1'b0; if_pc = 32'h804;
    tick();
    reset = 1'b1;
    #1;
    total++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_instr !== 32'h0 || ex_rd1 !== 32'h0 || ex_dst !== 5'd0) begin bad++; $display("FAIL async_reset got=%0b/%h/%h/%h/%0d want=all 0", ex_valid, ex_pc, ex_instr, ex_rd1, ex_dst); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_ready2 got=%0b want=1", id_ready); end
    tick();
    reset = 1'b0; ex_ready = 1'b1; if_instr = r_ins(5'd1, 5'd0, 5'd13, 6'h21);
    tick();
    if_valid = 1'b0;
    total++; if (ex_rd1 !== 32'h0 || ex_valid !== 1'b1) begin bad++; $display("FAIL rf_cleared got=%h/%0b want=0/1", ex_rd1, ex_valid); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_load_use();
    test_branch();
    test_forward();
    test_r0();
    test_stall_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
